// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU stage.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_SBC = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_NOT = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9,
    OP_MUL = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [3:0] opc);
    return (opc == OP_SHL) || (opc == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_seq_core.sv
// Combinational single-cycle unit: add/sub with carry-in, logic ops, zero flag.
// Shift opcodes pass a through with carry 0 (the zero-count case); MUL and 11-15 report illegal.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] y,
  output logic             c,
  output logic             z,
  output logic             legal
);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] addend_s;
  logic             carry_in_s;

  // Opcode decode and result selection
  always_comb begin
    addend_s   = b;
    carry_in_s = 1'b0;
    y          = a;
    c          = 1'b0;
    legal      = 1'b1;
    case (op)
      OP_ADD: begin addend_s = b;  carry_in_s = 1'b0; end
      OP_ADC: begin addend_s = b;  carry_in_s = cin;  end
      OP_SUB: begin addend_s = ~b; carry_in_s = 1'b1; end
      OP_SBC: begin addend_s = ~b; carry_in_s = cin;  end
      default: begin addend_s = b; carry_in_s = 1'b0; end
    endcase
    sum_s = {1'b0, a} + {1'b0, addend_s} + {{WIDTH{1'b0}}, carry_in_s};
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin y = sum_s[WIDTH-1:0]; c = sum_s[WIDTH]; end
      OP_AND:          y = a & b;
      OP_OR:           y = a | b;
      OP_XOR:          y = a ^ b;
      OP_NOT:          y = ~a;
      OP_SHL, OP_SHR:  y = a;
      default:         legal = 1'b0;
    endcase
    z = (y == {WIDTH{1'b0}});
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU stage: start/busy/done handshake, iterative shifts and optional MUL.
// Define ALU_SEQ_MUL_EN to make opcode 10 a WIDTH-cycle shift-add multiply.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             notReset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             cOut,
  output logic             zOut,
  output logic             notLoadStatus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_ZERO = '0;
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ZERO_W   = '0;

  state_e           state_r;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] sh_r;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    n_s;
  logic [3:0]       op_sel_s;
  logic [WIDTH-1:0] sh_src_s;
  logic [WIDTH-1:0] sh_nxt_s;
  logic             sh_bit_s;
  logic [WIDTH-1:0] core_y_s;
  logic             core_c_s;
  logic             core_z_s;
  logic             core_legal_s;

  assign n_s = b[CW-1:0];

  alu_seq_core #(.WIDTH(WIDTH)) u_core (
    .op    (op),
    .a     (a),
    .b     (b),
    .cin   (cIn),
    .y     (core_y_s),
    .c     (core_c_s),
    .z     (core_z_s),
    .legal (core_legal_s)
  );

  // One-bit shift step; in IDLE the first step is taken straight from the inputs
  always_comb begin
    op_sel_s = (state_r == ST_IDLE) ? op : op_r;
    sh_src_s = (state_r == ST_IDLE) ? a : sh_r;
    if (op_sel_s == OP_SHL) begin
      sh_nxt_s = {sh_src_s[WIDTH-2:0], 1'b0};
      sh_bit_s = sh_src_s[WIDTH-1];
    end else begin
      sh_nxt_s = {1'b0, sh_src_s[WIDTH-1:1]};
      sh_bit_s = sh_src_s[0];
    end
  end

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] acc_src_s;
  logic [2*WIDTH-1:0] mcand_src_s;
  logic [WIDTH-1:0]   mplier_src_s;
  logic [2*WIDTH-1:0] acc_nxt_s;

  // Shift-add step: one multiplier bit per cycle, the first one at accept
  always_comb begin
    if (state_r == ST_IDLE) begin
      acc_src_s    = '0;
      mcand_src_s  = {{WIDTH{1'b0}}, a};
      mplier_src_s = b;
    end else begin
      acc_src_s    = acc_r;
      mcand_src_s  = mcand_r;
      mplier_src_s = mplier_r;
    end
    acc_nxt_s = acc_src_s + (mplier_src_s[0] ? mcand_src_s : {(2*WIDTH){1'b0}});
  end
`endif

  // FSM, iteration state and registered outputs
  always_ff @(posedge clock) begin
    if (!notReset) begin
      state_r       <= ST_IDLE;
      op_r          <= 4'd0;
      sh_r          <= ZERO_W;
      cnt_r         <= CNT_ZERO;
      busy          <= 1'b0;
      done          <= 1'b0;
      y             <= ZERO_W;
      cOut          <= 1'b0;
      zOut          <= 1'b0;
      notLoadStatus <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
      acc_r         <= '0;
      mcand_r       <= '0;
      mplier_r      <= ZERO_W;
`endif
    end else begin
      done          <= 1'b0;
      notLoadStatus <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          busy <= 1'b0;
          if (start) begin
            op_r <= op;
            busy <= 1'b1;
            if (is_shift(op) && (n_s != CNT_ZERO)) begin
              sh_r  <= sh_nxt_s;
              cnt_r <= n_s - CNT_ONE;
              if (n_s == CNT_ONE) begin
                y             <= sh_nxt_s;
                cOut          <= sh_bit_s;
                zOut          <= (sh_nxt_s == ZERO_W);
                done          <= 1'b1;
                notLoadStatus <= 1'b0;
                state_r       <= ST_DONE;
              end else begin
                state_r <= ST_EXEC;
              end
            end
`ifdef ALU_SEQ_MUL_EN
            else if (op == OP_MUL) begin
              acc_r    <= acc_nxt_s;
              mcand_r  <= mcand_src_s << 1;
              mplier_r <= mplier_src_s >> 1;
              cnt_r    <= CW'(WIDTH - 1);
              state_r  <= ST_EXEC;
            end
`endif
            else begin
              // illegal opcodes complete without touching the result or flags
              if (core_legal_s) begin
                y             <= core_y_s;
                cOut          <= core_c_s;
                zOut          <= core_z_s;
                notLoadStatus <= 1'b0;
              end
              done    <= 1'b1;
              state_r <= ST_DONE;
            end
          end
        end
        ST_EXEC: begin
          cnt_r <= cnt_r - CNT_ONE;
`ifdef ALU_SEQ_MUL_EN
          if (op_r == OP_MUL) begin
            acc_r    <= acc_nxt_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            if (cnt_r == CNT_ONE) begin
              y             <= acc_nxt_s[WIDTH-1:0];
              cOut          <= |acc_nxt_s[2*WIDTH-1:WIDTH];
              zOut          <= (acc_nxt_s[WIDTH-1:0] == ZERO_W);
              done          <= 1'b1;
              notLoadStatus <= 1'b0;
              state_r       <= ST_DONE;
            end
          end else
`endif
          begin
            sh_r <= sh_nxt_s;
            if (cnt_r == CNT_ONE) begin
              y             <= sh_nxt_s;
              cOut          <= sh_bit_s;
              zOut          <= (sh_nxt_s == ZERO_W);
              done          <= 1'b1;
              notLoadStatus <= 1'b0;
              state_r       <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes reference-model results, monitor checks on done.
module tb_alu_seq;

  logic        clock = 1'b0;
  logic        notReset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [15:0] a = 16'd0;
  logic [15:0] b = 16'd0;
  logic        cIn = 1'b0;
  logic        busy, done, cOut, zOut, notLoadStatus;
  logic [15:0] y;

  alu_seq #(.WIDTH(16)) dut (
    .clock(clock), .notReset(notReset), .start(start), .op(op), .a(a), .b(b), .cIn(cIn),
    .busy(busy), .done(done), .y(y), .cOut(cOut), .zOut(zOut), .notLoadStatus(notLoadStatus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] y;
    logic        c;
    logic        z;
    logic        nls;
    int          lat;
    int          acc_cyc;
    int          done_cyc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          nvec = 0;
  int          nerr = 0;
  logic [15:0] m_y = 16'd0;
  logic        m_c = 1'b0;
  logic        m_z = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic, remembers the last flags for illegal ops
  function automatic exp_t model(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv,
                                 input logic ci);
    exp_t        e;
    int unsigned s, ai, bi, n, legal;
    ai = int'(av); bi = int'(bv); n = bi & 15; legal = 1; e.lat = 1; s = 0;
    e.y = m_y; e.c = m_c;
    case (o)
      4'd0: s = ai + bi;
      4'd1: s = ai + bi + int'(ci);
      4'd2: s = ai + (65535 - bi) + 1;
      4'd3: s = ai + (65535 - bi) + int'(ci);
      default: s = 0;
    endcase
    case (o)
      4'd0, 4'd1, 4'd2, 4'd3: begin e.y = s[15:0]; e.c = s[16]; end
      4'd4: begin e.y = av & bv; e.c = 1'b0; end
      4'd5: begin e.y = av | bv; e.c = 1'b0; end
      4'd6: begin e.y = av ^ bv; e.c = 1'b0; end
      4'd7: begin e.y = ~av;     e.c = 1'b0; end
      4'd8: begin
        s = ai << n; e.y = s[15:0]; e.c = (n == 0) ? 1'b0 : s[16]; e.lat = (n == 0) ? 1 : int'(n);
      end
      4'd9: begin
        e.y = 16'(ai >> n); e.c = (n == 0) ? 1'b0 : 1'((ai >> (n - 1)) & 1);
        e.lat = (n == 0) ? 1 : int'(n);
      end
`ifdef ALU_SEQ_MUL_EN
      4'd10: begin s = ai * bi; e.y = s[15:0]; e.c = (s[31:16] != 16'd0); e.lat = 16; end
`endif
      default: legal = 0;
    endcase
    if (legal != 0) begin
      e.z = (e.y == 16'd0); e.nls = 1'b0;
      m_y = e.y; m_c = e.c; m_z = e.z;
    end else begin
      e.z = m_z; e.nls = 1'b1;
    end
    return e;
  endfunction

  // Monitor: pops the scoreboard on every done pulse and polices busy/notLoadStatus otherwise
  always @(negedge clock) begin
    exp_t e;
    if (notReset) begin
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_done", 32'(done), 32'd0);
        end else begin
          e = q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
          chk("y", 32'(y), 32'(e.y));
          chk("cOut", 32'(cOut), 32'(e.c));
          chk("zOut", 32'(zOut), 32'(e.z));
          chk("notLoadStatus_done", 32'(notLoadStatus), 32'(e.nls));
          chk("busy_done", 32'(busy), 32'd1);
        end
      end else begin
        if (notLoadStatus !== 1'b1) chk("notLoadStatus_idle", 32'(notLoadStatus), 32'd1);
        if (q.size() > 0) begin
          if (cyc >= q[0].done_cyc) begin
            chk("done_missing", 32'(done), 32'd1);
            void'(q.pop_front());
          end else if (cyc > q[0].acc_cyc) begin
            chk("busy_exec", 32'(busy), 32'd1);
          end
        end
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv,
                       input logic ci, input bit hold);
    exp_t e;
    int   t;
    t = 0;
    @(negedge clock);
    while (busy !== 1'b0 && t < 100) begin @(negedge clock); t++; end
    if (t >= 100) chk("accept_timeout", 32'(busy), 32'd0);
    op = o; a = av; b = bv; cIn = ci; start = 1'b1;
    e = model(o, av, bv, ci);
    e.acc_cyc = cyc; e.done_cyc = cyc + e.lat;
    q.push_back(e);
    @(posedge clock);
    if (hold) begin
      t = 0;
      do begin
        @(negedge clock);
        op = 4'($urandom); a = 16'($urandom); b = 16'($urandom); cIn = 1'($urandom); t++;
      end while (done !== 1'b1 && t < 40);
      @(negedge clock);
      start = 1'b0;
    end else begin
      #1 start = 1'b0;
    end
  endtask

  task automatic reset_check(input string nm);
    @(negedge clock);
    notReset = 1'b0; start = 1'b0;
    q.delete();
    m_y = 16'd0; m_c = 1'b0; m_z = 1'b0;
    @(negedge clock);
    chk({nm, "_y"}, 32'(y), 32'd0);
    chk({nm, "_cOut"}, 32'(cOut), 32'd0);
    chk({nm, "_zOut"}, 32'(zOut), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_nls"}, 32'(notLoadStatus), 32'd1);
    notReset = 1'b1;
  endtask

  initial begin
    int t;
    repeat (2) @(negedge clock);
    reset_check("reset");
    issue(4'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);   // ADD wrap to zero
    issue(4'd3, 16'h0005, 16'h0005, 1'b1, 1'b0);   // SBC no borrow
    issue(4'd3, 16'h0005, 16'h0005, 1'b0, 1'b0);   // SBC borrow
    issue(4'd8, 16'h8001, 16'h0003, 1'b0, 1'b0);
    issue(4'd9, 16'h0005, 16'h0001, 1'b0, 1'b0);
    issue(4'd8, 16'h1234, 16'h0000, 1'b1, 1'b0);   // zero-count shift
    issue(4'd9, 16'hF0F0, 16'h0004, 1'b0, 1'b1);   // start held, inputs churn
    issue(4'd15, 16'h1111, 16'h2222, 1'b1, 1'b0);  // illegal keeps flags
    issue(4'd10, 16'h0100, 16'h0100, 1'b0, 1'b0);
    issue(4'd2, 16'h0003, 16'h0007, 1'b0, 1'b1);
    issue(4'd8, 16'hABCD, 16'h000A, 1'b0, 1'b0);   // aborted by reset
    repeat (3) @(negedge clock);
    reset_check("reset_exec");
    issue(4'd15, 16'h5555, 16'h0001, 1'b0, 1'b0);
    issue(4'd10, 16'h00FF, 16'h0003, 1'b0, 1'b0);
    for (int i = 0; i < 80; i++) begin
      issue(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0));
    end
    t = 0;
    while (q.size() != 0 && t < 200) begin @(negedge clock); t++; end
    chk("drain", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
